mode4_tree_sequencer: RTL and testbench

//  Sequences the 4-input, 3-stage pipelined mode4 adder tree for one dot-product/row reduction.
//  - Accepts NUM_GROUPS 4-element groups over a valid/ready stream.
//  - Drives the tree's stage2/stage1/stage0 run enables and its clear.
//  - Reports the accumulated sum with a result handshake.
//  - Sits between the attention-layer buffer readers and the mode4 adder tree.

---
 rtl/mode4_seq_pkg.sv | 21 ++
 rtl/mode4_run_delay.sv | 44 ++++
 rtl/mode4_tree_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mode4_tree_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode4_seq_pkg.sv
// ---------------------------------------------------------------------------
// mode4_seq_pkg
// Shared constants for the mode4 adder-tree sequencer.
//   - FSM state encodings (kept as plain localparams so older tools and
//     hand-written waveform decoders see stable numeric values).
//   - TREE_DRAIN_CYCLES: cycles between the last tree input and a settled
//     tree output (tree depth minus the input stage).
//   - TREE_GROUP_SIZE: operands the tree consumes per accepted group.
// ---------------------------------------------------------------------------
package mode4_seq_pkg;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] FEED  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam int TREE_DRAIN_CYCLES = 2;
    localparam int TREE_GROUP_SIZE   = 4;

endpackage

// File: rtl/mode4_run_delay.sv
// ---------------------------------------------------------------------------
// mode4_run_delay
// Two-flop shift line that turns the tree's input-stage run enable into the
// run enables of the two downstream stages, so every stage advances exactly
// when the data word it holds is valid. Bubbles travel down as 0 bits.
// Ports:
//   clk     in   system clock
//   clear   in   synchronous clear (driven by the tree reset)
//   run_in  in   stage2 run enable
//   run_d1  out  run_in delayed one cycle  (stage1 run)
//   run_d2  out  run_in delayed two cycles (stage0 run)
// ---------------------------------------------------------------------------
module mode4_run_delay (
    input  logic clk,
    input  logic clear,
    input  logic run_in,
    output logic run_d1,
    output logic run_d2
);

    logic d1_q, d1_d;
    logic d2_q, d2_d;

    // Next state of the shift line; a clear flushes both taps so no stale
    // enable from an aborted reduction can reach the accumulator.
    always_comb begin
        d1_d = run_in;
        d2_d = d1_q;
        if (clear) begin
            d1_d = 1'b0;
            d2_d = 1'b0;
        end
    end

    // Shift-line registers.
    always_ff @(posedge clk) begin
        d1_q <= d1_d;
        d2_q <= d2_d;
    end

    assign run_d1 = d1_q;
    assign run_d2 = d2_q;

endmodule

// File: rtl/mode4_tree_sequencer.sv
// ---------------------------------------------------------------------------
// mode4_tree_sequencer
// Sequences one row reduction through the 4-input, 3-stage pipelined mode4
// adder tree: clears the tree, streams num_groups groups in over a
// valid/ready handshake, waits for the pipeline to drain, then presents the
// accumulated sum with a result handshake.
// Optional feature macro: MODE4_SEQ_PERF_EN (stall / reduction counters).
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start, num_groups  begin a reduction of num_groups groups (IDLE only)
//   in_valid/in_ready  upstream group handshake
//   stage2/1/0_run     tree stage run enables
//   tree_reset         tree clear (reset or CLEAR state)
//   result_valid/ready result handshake
//   busy               not IDLE
//   stall_cycles       FEED cycles with no valid input (perf builds)
//   red_count          completed reductions (perf builds)
// ---------------------------------------------------------------------------
module mode4_tree_sequencer
    import mode4_seq_pkg::*;
#(
    parameter int CNT_WIDTH  = 8,
    parameter int PERF_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_groups,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  stage2_run,
    output logic                  stage1_run,
    output logic                  stage0_run,
    output logic                  tree_reset,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic                  busy,
    output logic [PERF_WIDTH-1:0] stall_cycles,
    output logic [PERF_WIDTH-1:0] red_count
);

    localparam logic [1:0] DRAIN_LAST = 2'(TREE_DRAIN_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [1:0]           drain_q, drain_d;
    logic                 accept;
    logic                 handshake;
    logic                 run_d1, run_d2;

    // Handshake-facing outputs come straight from the state register; they
    // are masked while reset is high so the reset cycle itself is quiet.
    assign in_ready     = ~reset & (state_q == FEED);
    assign result_valid = ~reset & (state_q == DONE);
    assign busy         = ~reset & (state_q != IDLE);
    assign tree_reset   = reset | (state_q == CLEAR);
    assign accept       = in_valid & in_ready;
    assign handshake    = result_valid & result_ready;
    assign stage2_run   = accept;

    // Main FSM next-state logic. The group counter only needs to reach
    // num_q-1, so a full 2**CNT_WIDTH-1 group reduction never wraps.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        num_d   = num_q;
        drain_d = drain_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = num_groups;
                    count_d = '0;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                drain_d = '0;
                state_d = (num_q != '0) ? FEED : DONE;
            end
            FEED: begin
                if (accept) begin
                    count_d = count_q + CNT_WIDTH'(1);
                    if (count_q == num_q - CNT_WIDTH'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == DRAIN_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            num_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            num_q   <= num_d;
            drain_q <= drain_d;
        end
    end

    // Downstream stage enables follow the input-stage enable; flushed by
    // the same clear that zeroes the tree.
    mode4_run_delay u_run_delay (
        .clk    (clk),
        .clear  (tree_reset),
        .run_in (stage2_run),
        .run_d1 (run_d1),
        .run_d2 (run_d2)
    );

    assign stage1_run = run_d1 & ~reset;
    assign stage0_run = run_d2 & ~reset;

`ifdef MODE4_SEQ_PERF_EN
    logic [PERF_WIDTH-1:0] stall_q, stall_d;
    logic [PERF_WIDTH-1:0] red_q, red_d;

    // Saturating perf counters: input starvation during FEED and completed
    // result handshakes. They survive across reductions until reset.
    always_comb begin
        stall_d = stall_q;
        red_d   = red_q;
        if ((state_q == FEED) && !in_valid && (stall_q != '1)) begin
            stall_d = stall_q + PERF_WIDTH'(1);
        end
        if (handshake && (red_q != '1)) begin
            red_d = red_q + PERF_WIDTH'(1);
        end
    end

    // Perf counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            red_q   <= '0;
        end else begin
            stall_q <= stall_d;
            red_q   <= red_d;
        end
    end

    assign stall_cycles = stall_q;
    assign red_count    = red_q;
`else
    assign stall_cycles = '0;
    assign red_count    = '0;
`endif

endmodule

// File: tb/tb_mode4_tree_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mode4_tree_sequencer
// Drives randomized reductions into the sequencer and compares every cycle
// against a reference built from the block's rules: which cycles may accept
// data, how run enables trail the accepted groups, when the result appears,
// and what sum an ideal accumulator driven by stage0_run would hold.
// ---------------------------------------------------------------------------
module tb_mode4_tree_sequencer;
    import mode4_seq_pkg::*;

    localparam int CNT_WIDTH  = 8;
    localparam int PERF_WIDTH = 16;
`ifdef MODE4_SEQ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [CNT_WIDTH-1:0]  num_groups;
    logic                  in_valid;
    logic                  in_ready;
    logic                  stage2_run;
    logic                  stage1_run;
    logic                  stage0_run;
    logic                  tree_reset;
    logic                  result_valid;
    logic                  result_ready;
    logic                  busy;
    logic [PERF_WIDTH-1:0] stall_cycles;
    logic [PERF_WIDTH-1:0] red_count;

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;
    int exp_red = 0;

    always #5 clk = ~clk;

    mode4_tree_sequencer #(.CNT_WIDTH(CNT_WIDTH), .PERF_WIDTH(PERF_WIDTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .num_groups   (num_groups),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stage2_run   (stage2_run),
        .stage1_run   (stage1_run),
        .stage0_run   (stage0_run),
        .tree_reset   (tree_reset),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .stall_cycles (stall_cycles),
        .red_count    (red_count)
    );

    // One reduction. mode: 0 random valid, 1 valid on alternate FEED cycles,
    // 2 valid always. fixed_val 0 picks random group sums. hold = cycles
    // result_ready stays low in DONE. abort_at > 0 asserts reset after that
    // many accepted groups.
    task automatic run_reduction(input string name, input int n, input int mode,
                                 input int fixed_val, input int hold, input int abort_at);
        int k, accepted, last_acc, rv_seen, acc, exp_sum, limit, cur_val;
        bit done, aborted, pending, exp_s1, exp_s0, acc_now, exp_rv, exp_rdy;
        logic [PERF_WIDTH-1:0] want_stall, want_red;
        int q[$];
        k = 0; accepted = 0; last_acc = -100; rv_seen = -1; acc = 0; exp_sum = 0;
        done = 0; aborted = 0; pending = 0; exp_s1 = 0; exp_s0 = 0; cur_val = 0;
        limit = 4 * n + hold + 40;
        num_groups = CNT_WIDTH'(n);
        start = 1'b1;
        in_valid = 1'b0;
        result_ready = 1'b0;
        @(posedge clk); #1;
        num_groups = CNT_WIDTH'($urandom);
        while (!done && !aborted && k < limit) begin
            if (!pending) begin
                if (accepted < n) begin
                    case (mode)
                        1: in_valid = (k >= 1) && ((k - 1) % 2 == 0);
                        2: in_valid = 1'b1;
                        default: in_valid = ($urandom_range(99) < 70);
                    endcase
                    cur_val = (fixed_val != 0) ? fixed_val : int'($urandom_range(60, 1));
                end else begin
                    in_valid = 1'b0;
                end
            end
            result_ready = (rv_seen >= 0) && (k - rv_seen >= hold);
            start = ($urandom_range(3) == 0);
            @(negedge clk);
            acc_now = in_valid & in_ready;
            exp_rdy = (k >= 1) && (accepted < n);
            exp_rv = (n == 0) ? (k >= 1) : ((accepted == n) && (k >= last_acc + TREE_DRAIN_CYCLES + 1));
            want_stall = PERF ? PERF_WIDTH'(exp_stall) : '0;
            checks++;
            if (tree_reset !== (k == 0)) begin
                errors++;
                $display("[TB] FAIL %s tree_reset k=%0d: got %b expected %b", name, k, tree_reset, (k == 0));
            end
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("[TB] FAIL %s busy k=%0d: got %b expected 1", name, k, busy);
            end
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("[TB] FAIL %s in_ready k=%0d: got %b expected %b", name, k, in_ready, exp_rdy);
            end
            checks++;
            if (stage2_run !== acc_now) begin
                errors++;
                $display("[TB] FAIL %s stage2_run k=%0d: got %b expected %b", name, k, stage2_run, acc_now);
            end
            checks++;
            if (stage1_run !== exp_s1) begin
                errors++;
                $display("[TB] FAIL %s stage1_run k=%0d: got %b expected %b", name, k, stage1_run, exp_s1);
            end
            checks++;
            if (stage0_run !== exp_s0) begin
                errors++;
                $display("[TB] FAIL %s stage0_run k=%0d: got %b expected %b", name, k, stage0_run, exp_s0);
            end
            checks++;
            if (result_valid !== exp_rv) begin
                errors++;
                $display("[TB] FAIL %s result_valid k=%0d: got %b expected %b", name, k, result_valid, exp_rv);
            end
            checks++;
            if (stall_cycles !== want_stall) begin
                errors++;
                $display("[TB] FAIL %s stall_cycles k=%0d: got %0d expected %0d", name, k, stall_cycles, want_stall);
            end
            if (stage0_run === 1'b1) begin
                acc += (q.size() > 0) ? q.pop_front() : 100000;
            end
            if (result_valid === 1'b1 && rv_seen < 0) begin
                rv_seen = k;
                checks++;
                if (acc !== exp_sum) begin
                    errors++;
                    $display("[TB] FAIL %s sum: got %0d expected %0d", name, acc, exp_sum);
                end
            end
            if (exp_rdy && !in_valid) exp_stall++;
            if (acc_now) begin
                q.push_back(cur_val);
                exp_sum += cur_val;
                accepted++;
                last_acc = k;
            end
            pending = in_valid && !acc_now;
            exp_s0 = exp_s1;
            exp_s1 = acc_now;
            if (result_valid === 1'b1 && result_ready) begin
                done = 1'b1;
                exp_red++;
            end
            if (abort_at > 0 && accepted == abort_at) aborted = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        start = 1'b0;
        result_ready = 1'b0;
        if (aborted) begin
            reset = 1'b1;
            in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0 || stage2_run !== 1'b0 || tree_reset !== 1'b1 || result_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s during_reset: got rdy=%b s2=%b tr=%b rv=%b expected 0 0 1 0",
                         name, in_ready, stage2_run, tree_reset, result_valid);
            end
            @(posedge clk); #1;
            reset = 1'b0;
            in_valid = 1'b0;
            exp_stall = 0;
            exp_red = 0;
            repeat (4) begin
                @(negedge clk);
                checks++;
                if ({in_ready, stage2_run, stage1_run, stage0_run, result_valid, busy, tree_reset} !== 7'b0
                    || stall_cycles !== '0 || red_count !== '0) begin
                    errors++;
                    $display("[TB] FAIL %s after_reset: got rdy=%b s2=%b s1=%b s0=%b rv=%b busy=%b tr=%b stall=%0d red=%0d expected all 0",
                             name, in_ready, stage2_run, stage1_run, stage0_run, result_valid, busy, tree_reset,
                             stall_cycles, red_count);
                end
            end
            @(posedge clk); #1;
        end else begin
            in_valid = 1'b0;
            checks++;
            if (!done) begin
                errors++;
                $display("[TB] FAIL %s timeout: got no handshake after %0d cycles, expected one", name, limit);
            end
            want_red = PERF ? PERF_WIDTH'(exp_red) : '0;
            checks++;
            if (busy !== 1'b0 || result_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s idle_after: got busy=%b rv=%b expected 0 0", name, busy, result_valid);
            end
            checks++;
            if (red_count !== want_red) begin
                errors++;
                $display("[TB] FAIL %s red_count: got %0d expected %0d", name, red_count, want_red);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        in_valid = 1'b1;
        result_ready = 1'b0;
        num_groups = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({tree_reset, in_ready, stage2_run, stage1_run, stage0_run, result_valid, busy} !== 7'b1000000
            || stall_cycles !== '0 || red_count !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: got tr=%b rdy=%b s2=%b s1=%b s0=%b rv=%b busy=%b expected 1 0 0 0 0 0 0",
                     tree_reset, in_ready, stage2_run, stage1_run, stage0_run, result_valid, busy);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (tree_reset !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got tr=%b busy=%b rdy=%b expected 0 0 0", tree_reset, busy, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_stream();
        run_reduction("full16", 16, 2, TREE_GROUP_SIZE, 0, 0);
    endtask

    task automatic test_bubbles();
        run_reduction("bubbles4", 4, 1, 0, 0, 0);
    endtask

    task automatic test_zero_groups();
        run_reduction("zero", 0, 0, 0, 0, 0);
    endtask

    task automatic test_result_hold();
        run_reduction("hold5", 6, 0, 0, 5, 0);
    endtask

    task automatic test_reset_mid_feed();
        run_reduction("abort7", 16, 2, TREE_GROUP_SIZE, 0, 7);
        run_reduction("after_abort", 16, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_reduction("b2b_first", 5, 0, 0, 0, 0);
        run_reduction("b2b_second", 3, 0, 0, 1, 0);
        run_reduction("b2b_third", 1, 2, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_reduction("random", int'($urandom_range(40, 1)), int'($urandom_range(2)), 0,
                          int'($urandom_range(3)), 0);
        end
        run_reduction("max255", 255, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_bubbles();
        test_zero_groups();
        test_result_hold();
        test_reset_mid_feed();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
